// File: rtl/seven_segment_display_driver.sv
// Multi-digit seven-segment driver: binary value -> BCD via sequential shift-add-3,
// then glyph lookup with leading-zero blanking, "Err" overflow, blink and polarity.
module seven_segment_display_driver #(
  parameter int DIGITS      = 6,
  parameter int VALUE_WIDTH = 20,
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BLINK_HZ    = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   load,
  output logic                   busy,
  input  logic                   blank_leading,
  input  logic                   blink_enable,
  output logic                   overflow,
  output logic [8*DIGITS-1:0]    segments
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int BCD_W = 4 * DIGITS;
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam int CNT_W  = $clog2(VALUE_WIDTH + 1);
  localparam int HALF   = CLOCK_FREQ / (2 * BLINK_HZ);
  localparam int HALF_P = (HALF < 1) ? 1 : HALF;
  localparam int BLK_W  = (HALF_P > 1) ? $clog2(HALF_P) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t                 state, state_next;
  logic [VALUE_WIDTH-1:0] shift_q;
  logic [BCD_W-1:0]       bcd_q, bcd_adj, disp_q;
  logic                   disp_valid;
  logic [CNT_W-1:0]       count_q;
  logic                   ovf_pend;
  logic                   capture, shift_en, update;
  logic [BLK_W-1:0]       blk_cnt;
  logic                   phase;
  logic [8*DIGITS-1:0]    seg_ah;
  logic                   lead;
  logic [3:0]             nib;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3F;
      4'd1: return 8'h06;
      4'd2: return 8'h5B;
      4'd3: return 8'h4F;
      4'd4: return 8'h66;
      4'd5: return 8'h6D;
      4'd6: return 8'h7D;
      4'd7: return 8'h07;
      4'd8: return 8'h7F;
      4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    shift_en   = 1'b0;
    update     = 1'b0;
    case (state)
      IDLE: if (load) begin
        capture    = 1'b1;
        state_next = CONVERT;
      end
      CONVERT: begin
        shift_en = 1'b1;
        if (count_q == CNT_W'(1)) state_next = UPDATE;
      end
      UPDATE: begin
        update     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  // NOTE: datapath registers are reset too, so an aborted conversion leaves a blank display, not stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      count_q    <= '0;
      ovf_pend   <= 1'b0;
      disp_q     <= '0;
      disp_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (capture) begin
        shift_q  <= value;
        bcd_q    <= '0;
        count_q  <= CNT_W'(VALUE_WIDTH);
        ovf_pend <= (64'(value) > MAX_VAL);
      end
      if (shift_en) begin
        {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
        count_q          <= count_q - CNT_W'(1);
      end
      if (update) begin
        disp_q     <= bcd_q;
        disp_valid <= 1'b1;
        overflow   <= ovf_pend;
      end
    end
  end

  // Free-running half-period counter; phase flips each time it wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (blk_cnt == BLK_W'(HALF_P - 1)) begin
      blk_cnt <= '0;
      phase   <= ~phase;
    end else begin
      blk_cnt <= blk_cnt + BLK_W'(1);
    end
  end

  // Walk from the top digit down; lead stays set until the first nonzero digit.
  always_comb begin
    seg_ah = '0;
    lead   = 1'b1;
    nib    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = disp_q[4*k +: 4];
      if (k > 0 && lead && nib == 4'd0 && blank_leading) seg_ah[8*k +: 8] = 8'h00;
      else                                                 seg_ah[8*k +: 8] = glyph(nib);
      if (nib != 4'd0) lead = 1'b0;
    end
    if (overflow) begin
      seg_ah        = '0;
      seg_ah[23:0]  = {8'h79, 8'h50, 8'h50};
    end
    if (!disp_valid || (blink_enable && phase)) seg_ah = '0;
  end

  assign segments = (ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;

endmodule

// File: tb/tb_seven_segment_display_driver.sv
// Scoreboard bench: predicted conversions are queued at acceptance and checked when busy falls;
// a second instance with a fast blink clock and active-high outputs covers blinking.
module tb_seven_segment_display_driver;
  localparam int DIGITS = 6;
  localparam int VW     = 20;
  localparam longint unsigned MAXV = 999999;
  localparam logic [7:0] GLYPH [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic clock = 1'b0;
  logic reset;
  logic [VW-1:0] value, value_b;
  logic load, load_b, busy, busy_b, bl, bl_b, blink, blink_b, ovf, ovf_b;
  logic [8*DIGITS-1:0] segs, segs_b;

  always #5 clock = ~clock;

  seven_segment_display_driver #(.DIGITS(DIGITS), .VALUE_WIDTH(VW), .CLOCK_FREQ(50000000),
                                 .BLINK_HZ(2), .ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load), .busy(busy),
    .blank_leading(bl), .blink_enable(blink), .overflow(ovf), .segments(segs));

  seven_segment_display_driver #(.DIGITS(DIGITS), .VALUE_WIDTH(VW), .CLOCK_FREQ(8),
                                 .BLINK_HZ(1), .ACTIVE_LOW(0)) dut_b (
    .clock(clock), .reset(reset), .value(value_b), .load(load_b), .busy(busy_b),
    .blank_leading(bl_b), .blink_enable(blink_b), .overflow(ovf_b), .segments(segs_b));

  // Reference model: decimal digits by division, then glyph/blank/dark/polarity rules.
  function automatic logic [47:0] model_segs(input longint unsigned v, input bit bl_on,
                                             input bit dark, input bit al);
    logic [47:0] s = '0;
    longint unsigned p = 1;
    int dig [6];
    int msd = 0;
    if (v > MAXV) begin
      s[23:0] = {8'h79, 8'h50, 8'h50};
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        dig[k] = int'((v / p) % 10);
        if (dig[k] != 0) msd = k;
        p = p * 10;
      end
      for (int k = 0; k < DIGITS; k++)
        if (!(bl_on && k > msd)) s[8*k +: 8] = GLYPH[dig[k]];
    end
    if (dark) s = '0;
    if (al) s = ~s;
    return s;
  endfunction

  typedef struct {
    longint unsigned v;
    int              done;
    logic [47:0]     exp_seg;
    bit              exp_ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_blink;
  int   passed = 0;
  int   total = 0;
  int   free_at = 0;
  bit   prev_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset)
    if (reset) n_blink <= 0;
    else       n_blink <= n_blink + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor and acceptance predictor, both sampled on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      free_at   = 0;
      prev_busy = 1'b0;
    end else begin
      check("busy", longint'(busy), longint'(cyc + 2 <= free_at));
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check($sformatf("latency v=%0d", mon_e.v), cyc, mon_e.done);
          check($sformatf("segs v=%0d", mon_e.v), segs, mon_e.exp_seg);
          check($sformatf("ovf v=%0d", mon_e.v), longint'(ovf), longint'(mon_e.exp_ovf));
        end
      end else if (q.size() != 0 && cyc > q[0].done + 2) begin
        check("done_timeout", cyc, q[0].done);
        void'(q.pop_front());
      end
      prev_busy = busy;
      if (load && cyc + 1 >= free_at) begin
        q.push_back('{v: value, done: cyc + 1 + VW + 1,
                      exp_seg: model_segs(value, bl, 1'b0, 1'b1), exp_ovf: (value > MAXV)});
        free_at = cyc + 1 + VW + 2;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [VW-1:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain", q.size(), 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; bl = 1'b1; blink = 1'b0;
    load_b = 1'b0; value_b = '0; bl_b = 1'b1; blink_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_segs", segs, 48'hFFFF_FFFF_FFFF);
    check("rst_segs_b", segs_b, 0);
    reset = 1'b0;
    tick();

    do_load(123);      wait_idle();
    check("lit_123", segs, 48'hFFFFFF_F9A4B0);
    bl = 1'b0; #1;
    check("lit_123_noblank", segs, 48'hC0C0C0_F9A4B0);
    bl = 1'b1;
    do_load(0);        wait_idle();
    check("lit_0", segs, 48'hFFFFFF_FFFFC0);
    do_load(999999);   wait_idle();
    check("lit_999999", segs, 48'h909090_909090);
    check("ovf_999999", ovf, 0);
    do_load(1000000);  wait_idle();
    check("lit_err", segs, 48'hFFFFFF_86AFAF);
    check("ovf_1000000", ovf, 1);
    do_load(42);       wait_idle();
    check("lit_42", segs, 48'hFFFFFF_FF99A4);
    check("ovf_42", ovf, 0);

    // Load held high: 7 accepted first, 8 only when the engine is free again.
    value = 7; load = 1'b1;
    repeat (5) tick();
    value = 8;
    repeat (25) tick();
    load = 1'b0;
    wait_idle();
    check("lit_held_8", segs, 48'hFFFFFF_FFFF80);

    // Reset in the middle of a conversion, after an overflow was displayed.
    do_load(2000000);  wait_idle();
    do_load(555);
    repeat (9) tick();
    reset = 1'b1; #1;
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_segs", segs, 48'hFFFF_FFFF_FFFF);
    tick(); tick();
    reset = 1'b0;
    tick();
    do_load(555);      wait_idle();
    check("lit_555", segs, 48'hFFFFFF_929292);

    for (int n = 0; n < 40; n++) begin
      logic [VW-1:0] v;
      bl = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v = VW'($urandom_range(0, 99));
        1:       v = VW'($urandom_range(0, 999999));
        2:       v = VW'($urandom_range(1000000, 1048575));
        default: v = VW'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) tick();
      value = v; load = 1'b1;
      tick();
      repeat ($urandom_range(0, 3)) begin
        value = VW'($urandom);
        tick();
      end
      load = 1'b0;
      wait_idle();
    end

    // Blink: half period of 4 cycles on the second instance.
    value_b = 5; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    repeat (23) tick();
    blink_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("blink_on", segs_b, model_segs(5, 1'b1, ((n_blink / 4) % 2) == 1, 1'b0));
    end
    blink_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("blink_off", segs_b, 48'h0000_0000_006D);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
